// File: rtl/code_output_buffer_pkg.sv
// Shared definitions for the code output buffer and the compressor top that
// uses it: default code width, byte width and packer state encodings.
package code_output_buffer_pkg;

  localparam int CODE_WIDTH_DEF = 9;
  localparam int BYTE_W         = 8;

  typedef enum logic [1:0] {
    ST_PACK  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } obuf_state_e;

  // Two codes minus the guaranteed byte already drained always fit.
  function automatic int acc_width(input int code_width);
    return 2 * code_width - 2;
  endfunction

endpackage

// File: rtl/code_output_buffer_byte_fifo.sv
// byte_fifo: byte FIFO with a registered show-ahead head (o_data/o_valid).
// DEPTH is the total capacity, head register included; power of two, >= 2.
module byte_fifo
  import code_output_buffer_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_mem_cnt;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;

  logic              w_write;
  logic              w_read;
  logic              w_pop;
  logic [AW:0]       w_level;

  assign w_level = r_mem_cnt + {{AW{1'b0}}, r_valid};
  assign o_full  = (w_level == (AW+1)'(DEPTH));
  assign o_empty = (w_level == '0);
  assign w_pop   = r_valid && i_pop;
  assign w_write = i_push && !o_full;
  // Refill the head register whenever it is empty or being consumed.
  assign w_read  = (r_mem_cnt != '0) && (!r_valid || w_pop);

  // NOTE: storage has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_mem_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_read)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_mem_cnt <= r_mem_cnt + (AW+1)'(w_write) - (AW+1)'(w_read);
      if (w_read) begin
        r_data  <= r_mem[r_rd_ptr];
        r_valid <= 1'b1;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/code_output_buffer.sv
// code_output_buffer: packs variable-width codes LSB-first into bytes and queues
// them in byte_fifo. Define OUTBUF_BYTECOUNT_EN to add the ByteCount output.
module code_output_buffer
  import code_output_buffer_pkg::*;
#(
  parameter int CODE_WIDTH = CODE_WIDTH_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RequestOutBuffer,
  input  logic                  CloseBuffer,
  input  logic [CODE_WIDTH-1:0] Code,
  output logic                  Busy,
  output logic [BYTE_W-1:0]     ByteOut,
  output logic                  ByteValid,
  input  logic                  ByteReady,
  output logic                  Closed,
`ifdef OUTBUF_BYTECOUNT_EN
  output logic [15:0]           ByteCount,
`endif
  output logic                  Overrun
);

  localparam int ACC_W = acc_width(CODE_WIDTH);
  localparam int CNT_W = $clog2(ACC_W + 1);

  obuf_state_e      r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_closed;
  logic             r_overrun;

  obuf_state_e      w_state_nxt;
  logic [ACC_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_push;
  logic             w_cnt_ge8;
  logic             w_accept_req;
  logic             w_accept_close;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_pop;

  assign w_cnt_ge8      = (r_bit_cnt >= CNT_W'(BYTE_W));
  assign Busy           = w_cnt_ge8 || (r_state != ST_PACK);
  assign w_accept_req   = RequestOutBuffer && !Busy;
  assign w_accept_close = CloseBuffer && !Busy;
  assign w_pop          = ByteValid && ByteReady;

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latch inferred.
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_bit_cnt;
    w_push      = 1'b0;

    if (w_cnt_ge8 && !w_fifo_full) begin
      w_push    = 1'b1;
      w_acc_nxt = r_acc >> BYTE_W;
      w_cnt_nxt = r_bit_cnt - CNT_W'(BYTE_W);
    end else if (r_state == ST_FLUSH && !w_cnt_ge8 && r_bit_cnt != '0 && !w_fifo_full) begin
      // Bits above BitCnt are already zero, so the partial byte is self-padded.
      w_push    = 1'b1;
      w_acc_nxt = '0;
      w_cnt_nxt = '0;
    end

    // Acceptance implies BitCnt < 8, so it never coincides with a full-byte push.
    if (w_accept_req) begin
      w_acc_nxt = r_acc | (ACC_W'(Code) << r_bit_cnt);
      w_cnt_nxt = r_bit_cnt + CNT_W'(CODE_WIDTH);
    end

    case (r_state)
      ST_PACK:  if (w_accept_close)    w_state_nxt = ST_FLUSH;
      ST_FLUSH: if (r_bit_cnt == '0)   w_state_nxt = ST_DONE;
      default:  w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_PACK;
      r_acc     <= '0;
      r_bit_cnt <= '0;
      r_closed  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_bit_cnt <= w_cnt_nxt;
      if (w_state_nxt == ST_DONE) r_closed <= 1'b1;
      if ((RequestOutBuffer || CloseBuffer) && Busy) r_overrun <= 1'b1;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_acc[BYTE_W-1:0]),
    .i_pop   (ByteReady && !w_fifo_empty),
    .o_data  (ByteOut),
    .o_valid (ByteValid),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign Closed  = r_closed;
  assign Overrun = r_overrun;

`ifdef OUTBUF_BYTECOUNT_EN
  logic [15:0] r_byte_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_count <= '0;
    end else if (w_pop && r_byte_count != 16'hFFFF) begin
      r_byte_count <= r_byte_count + 16'd1;
    end
  end

  assign ByteCount = r_byte_count;
`endif

endmodule

// File: tb/tb_code_output_buffer.sv
// Directed self-checking bench for code_output_buffer: packing, back-pressure,
// flush padding, overrun, reset during flush and the optional byte counter.
module tb_code_output_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       close = 1'b0;
  logic       ready = 1'b0;
  logic [8:0] code = '0;
  logic       busy;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       closed;
  logic       overrun;
`ifdef OUTBUF_BYTECOUNT_EN
  logic [15:0] byte_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  code_output_buffer #(
    .CODE_WIDTH (9),
    .FIFO_DEPTH (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .RequestOutBuffer (req),
    .CloseBuffer      (close),
    .Code             (code),
    .Busy             (busy),
    .ByteOut          (byte_out),
    .ByteValid        (byte_valid),
    .ByteReady        (ready),
    .Closed           (closed),
`ifdef OUTBUF_BYTECOUNT_EN
    .ByteCount        (byte_count),
`endif
    .Overrun          (overrun)
  );

  always #5 clk = ~clk;

  // Bytes handed over downstream, sampled mid-cycle when inputs are stable.
  always @(negedge clk) begin
    if (!reset && byte_valid && ready) got_q.push_back(byte_out);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 1'b0;
    close = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    int n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check({tag, "_busy_timeout"}, busy, 0);
  endtask

  task automatic send_code(input string tag, input logic [8:0] c);
    wait_not_busy(tag);
    req  = 1'b1;
    code = c;
    tick();
    req  = 1'b0;
  endtask

  task automatic send_close(input string tag);
    wait_not_busy(tag);
    close = 1'b1;
    tick();
    close = 1'b0;
  endtask

  task automatic send_both(input string tag, input logic [8:0] c);
    wait_not_busy(tag);
    req   = 1'b1;
    close = 1'b1;
    code  = c;
    tick();
    req   = 1'b0;
    close = 1'b0;
  endtask

  task automatic wait_closed(input string tag);
    int n = 0;
    while (!closed && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_closed"}, closed, 1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_b%0d", tag, i),
            (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD_BEEF,
            {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_valid", byte_valid, 0);
    check("rst_byte", byte_out, 8'h00);
    check("rst_closed", closed, 0);
    check("rst_overrun", overrun, 0);

    // 0x1FF, 0x001, close -> FF 03 00; first byte two edges after the request.
    ready = 1'b1;
    got_q.delete();
    send_code("t1", 9'h1FF);
    check("t1_lat_e0", byte_valid, 0);
    tick();
    check("t1_lat_e1", byte_valid, 0);
    tick();
    check("t1_lat_e2_valid", byte_valid, 1);
    check("t1_lat_e2_byte", byte_out, 8'hFF);
    send_code("t1", 9'h001);
    send_close("t1");
    wait_closed("t1");
    drain(6);
    exp_q = '{8'hFF, 8'h03, 8'h00};
    check_stream("t1");
    check("t1_busy_done", busy, 1);
`ifdef OUTBUF_BYTECOUNT_EN
    check("t1_byte_count", byte_count, 16'd3);
`endif
    req = 1'b1;
    tick();
    req = 1'b0;
    drain(4);
    check("t1_overrun_done", overrun, 1);
    check("t1_len_after_done", got_q.size(), 3);

    // Back-pressure: eight zero codes fill the FIFO and stall the packer.
    do_reset();
    ready = 1'b0;
    got_q.delete();
    for (int i = 0; i < 8; i++) send_code("t2", 9'h000);
    drain(5);
    check("t2_stall_busy", busy, 1);
    check("t2_stall_valid", byte_valid, 1);
    check("t2_stall_none", got_q.size(), 0);
    check("t2_overrun", overrun, 0);
    ready = 1'b1;
    drain(30);
    exp_q.delete();
    repeat (9) exp_q.push_back(8'h00);
    check_stream("t2");
    check("t2_busy_after", busy, 0);

    // Close with two leftover bits -> exactly one padded byte.
    do_reset();
    ready = 1'b1;
    got_q.delete();
    send_code("t3", 9'h0AA);
    send_code("t3", 9'h155);
    send_close("t3");
    wait_closed("t3");
    drain(6);
    exp_q = '{8'hAA, 8'hAA, 8'h02};
    check_stream("t3");

    // Request while Busy is dropped and flags Overrun until reset.
    do_reset();
    ready = 1'b1;
    got_q.delete();
    send_code("t4", 9'h1FF);
    check("t4_busy_before", busy, 1);
    req  = 1'b1;
    code = 9'h0AB;
    tick();
    req  = 1'b0;
    check("t4_overrun_set", overrun, 1);
    send_code("t4", 9'h001);
    send_close("t4");
    wait_closed("t4");
    drain(6);
    exp_q = '{8'hFF, 8'h03, 8'h00};
    check_stream("t4");
    check("t4_overrun_held", overrun, 1);
    do_reset();
    check("t4_overrun_cleared", overrun, 0);

    // Reset in FLUSH with three bytes queued, then a fresh stream.
    ready = 1'b0;
    got_q.delete();
    send_code("t5", 9'h1FF);
    send_code("t5", 9'h001);
    send_both("t5", 9'h0AA);
    tick();
    check("t5_pre_valid", byte_valid, 1);
    check("t5_pre_busy", busy, 1);
    check("t5_pre_closed", closed, 0);
    reset = 1'b1;
    tick();
    check("t5_rst_valid", byte_valid, 0);
    check("t5_rst_closed", closed, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_byte", byte_out, 8'h00);
`ifdef OUTBUF_BYTECOUNT_EN
    check("t5_rst_count", byte_count, 16'd0);
`endif
    reset = 1'b0;
    ready = 1'b1;
    got_q.delete();
    send_code("t5", 9'h0AA);
    send_code("t5", 9'h155);
    send_close("t5");
    wait_closed("t5");
    drain(6);
    exp_q = '{8'hAA, 8'hAA, 8'h02};
    check_stream("t5");

    // Request and close together: the code is appended before flushing.
    do_reset();
    ready = 1'b1;
    got_q.delete();
    send_code("t6", 9'h1FF);
    send_both("t6", 9'h001);
    wait_closed("t6");
    drain(6);
    exp_q = '{8'hFF, 8'h03, 8'h00};
    check_stream("t6");
    check("t6_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
